// File: rtl/dec_pkg.sv
// Shared encodings for the dec_scan one-hot decoder/scanner.
// State values and mode constants are fixed so other blocks can decode them directly.
package dec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dwell_cnt.sv
// Load/decrement dwell counter for the scan engine.
// It saturates at zero, and a load has priority over the decrement.
module dwell_cnt #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [DWELL_W-1:0] val,
    output logic               zero
);

    logic [DWELL_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en) begin
            if (load) begin
                r_cnt <= val;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/dec_scan.sv
// Registered one-hot decoder. DIRECT mode decodes a select that is accepted through a handshake.
// SCAN mode steps through every output position, and each position dwells for dwell+1 cycles.
module dec_scan
    import dec_pkg::*;
#(
    parameter  int SEL_W   = 3,
    localparam int OUT_W   = 2**SEL_W,
    parameter  int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   ou,
    output logic [SEL_W-1:0]   idx,
    output logic               ou_valid,
    output logic               wrap
);

    state_t             r_state;
    state_t             w_nextState;
    logic [OUT_W-1:0]   r_ou;
    logic [OUT_W-1:0]   w_nextOu;
    logic [SEL_W-1:0]   r_idx;
    logic [SEL_W-1:0]   w_nextIdx;
    logic               r_ouValid;
    logic               w_nextOuValid;
    logic               r_wrap;
    logic               w_nextWrap;
    logic               w_accept;
    logic               w_cntLoad;
    logic               w_cntZero;
    logic [DWELL_W-1:0] w_cntVal;

    assign in_ready = en & (mode == MODE_DIRECT) & ~rst;
    assign w_accept = in_valid & in_ready;

    // Leaving SCAN loads zero into the counter, so a later re-entry always starts from a fresh dwell.
    always_comb begin
        w_nextState   = r_state;
        w_nextOu      = r_ou;
        w_nextIdx     = r_idx;
        w_nextOuValid = r_ouValid;
        w_nextWrap    = 1'b0;
        w_cntLoad     = 1'b0;
        w_cntVal      = '0;
        if (en) begin
            if (mode == MODE_SCAN) begin
                w_nextState = SCAN;
                if (r_state != SCAN) begin
                    w_nextOu      = {{(OUT_W-1){1'b0}}, 1'b1};
                    w_nextIdx     = '0;
                    w_nextOuValid = 1'b1;
                    w_cntLoad     = 1'b1;
                    w_cntVal      = dwell;
                end else if (w_cntZero) begin
                    w_nextOu      = {r_ou[OUT_W-2:0], r_ou[OUT_W-1]};
                    w_nextIdx     = r_idx + 1'b1;
                    w_nextOuValid = 1'b1;
                    w_nextWrap    = &r_idx;
                    w_cntLoad     = 1'b1;
                    w_cntVal      = dwell;
                end
            end else begin
                w_nextState = DIRECT;
                w_cntLoad   = 1'b1;
                if (w_accept) begin
                    w_nextOu      = OUT_W'(1) << in;
                    w_nextIdx     = in;
                    w_nextOuValid = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ou      <= '0;
            r_idx     <= '0;
            r_ouValid <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_ou      <= w_nextOu;
            r_idx     <= w_nextIdx;
            r_ouValid <= w_nextOuValid;
            r_wrap    <= w_nextWrap;
        end
    end

    dwell_cnt #(
        .DWELL_W(DWELL_W)
    ) u_dwellCnt (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .load (w_cntLoad),
        .val  (w_cntVal),
        .zero (w_cntZero)
    );

    assign ou       = r_ou;
    assign idx      = r_idx;
    assign ou_valid = r_ouValid;
    assign wrap     = r_wrap;

endmodule

// File: tb/tb_dec_scan.sv
// Directed testbench for dec_scan. It covers reset, the DIRECT sweep, SCAN stepping with and without dwell,
// freezing through en, and switching mode or asserting reset while the block is running.
module tb_dec_scan;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic       inValid;
    logic       inReady;
    logic [2:0] selIn;
    logic [7:0] dwell;
    logic [7:0] ou;
    logic [2:0] idx;
    logic       ouValid;
    logic       wrap;

    int checks   = 0;
    int failures = 0;

    dec_scan #(
        .SEL_W  (3),
        .DWELL_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .in_valid (inValid),
        .in_ready (inReady),
        .in       (selIn),
        .dwell    (dwell),
        .ou       (ou),
        .idx      (idx),
        .ou_valid (ouValid),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; mode = 1'b1; inValid = 1'b0; selIn = 3'd0; dwell = 8'd0;
        #1;
        checks++;
        if (inReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready_pre: got %b expected 0", inReady); end
        tick;
        tick;
        checks++;
        if (ou !== 8'h00) begin failures++; $display("[TB] FAIL reset_ou: got %h expected 00", ou); end
        checks++;
        if (ouValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", ouValid); end
        checks++;
        if (wrap !== 1'b0 || idx !== 3'd0) begin failures++; $display("[TB] FAIL reset_wrap_idx: got %b/%0d expected 0/0", wrap, idx); end
        checks++;
        if (inReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0", inReady); end
        rst = 1'b0;
    endtask

    task automatic test_direct_sweep;
        logic [7:0] expOu;
        mode = 1'b0; inValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            selIn = 3'(i);
            #1;
            checks++;
            if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL direct_ready[%0d]: got %b expected 1", i, inReady); end
            tick;
            expOu = 8'h01 << i;
            checks++;
            if (ou !== expOu || idx !== 3'(i) || ouValid !== 1'b1)
                begin failures++; $display("[TB] FAIL direct_ou[%0d]: got %h/%0d/%b expected %h/%0d/1", i, ou, idx, ouValid, expOu, i); end
            checks++;
            if (ou !== (8'h01 << idx)) begin failures++; $display("[TB] FAIL direct_onehot[%0d]: got %h idx %0d", i, ou, idx); end
        end
        inValid = 1'b0;
        tick;
        checks++;
        if (ou !== 8'h80 || idx !== 3'd7) begin failures++; $display("[TB] FAIL direct_hold: got %h/%0d expected 80/7", ou, idx); end
    endtask

    task automatic test_scan_dwell0;
        logic [7:0] expOu;
        dwell = 8'd0; mode = 1'b1;
        tick;
        checks++;
        if (ou !== 8'h01 || idx !== 3'd0 || wrap !== 1'b0 || inReady !== 1'b0)
            begin failures++; $display("[TB] FAIL scan0_entry: got %h/%0d/%b/%b expected 01/0/0/0", ou, idx, wrap, inReady); end
        for (int k = 1; k <= 16; k++) begin
            tick;
            expOu = 8'h01 << (k % 8);
            checks++;
            if (ou !== expOu || idx !== 3'(k % 8))
                begin failures++; $display("[TB] FAIL scan0_step[%0d]: got %h/%0d expected %h/%0d", k, ou, idx, expOu, k % 8); end
            checks++;
            if (wrap !== ((k % 8) == 0)) begin failures++; $display("[TB] FAIL scan0_wrap[%0d]: got %b expected %b", k, wrap, (k % 8) == 0); end
        end
    endtask

    task automatic test_scan_dwell2;
        int expIdx;
        mode = 1'b0;
        tick;
        mode = 1'b1; dwell = 8'd2;
        tick;
        checks++;
        if (ou !== 8'h01 || idx !== 3'd0) begin failures++; $display("[TB] FAIL scan2_entry: got %h/%0d expected 01/0", ou, idx); end
        for (int t = 1; t <= 24; t++) begin
            tick;
            expIdx = (t / 3) % 8;
            checks++;
            if (idx !== 3'(expIdx) || ou !== (8'h01 << expIdx))
                begin failures++; $display("[TB] FAIL scan2_step[%0d]: got %h/%0d expected idx %0d", t, ou, idx, expIdx); end
            checks++;
            if (wrap !== (t == 24)) begin failures++; $display("[TB] FAIL scan2_wrap[%0d]: got %b expected %b", t, wrap, t == 24); end
        end
        dwell = 8'd0;
        tick;
        checks++;
        if (idx !== 3'd0) begin failures++; $display("[TB] FAIL scan2_chg_a: got %0d expected 0", idx); end
        tick;
        checks++;
        if (idx !== 3'd0) begin failures++; $display("[TB] FAIL scan2_chg_b: got %0d expected 0", idx); end
        tick;
        checks++;
        if (idx !== 3'd1 || ou !== 8'h02) begin failures++; $display("[TB] FAIL scan2_chg_c: got %h/%0d expected 02/1", ou, idx); end
        tick;
        checks++;
        if (idx !== 3'd2 || ou !== 8'h04) begin failures++; $display("[TB] FAIL scan2_chg_d: got %h/%0d expected 04/2", ou, idx); end
    endtask

    task automatic test_freeze;
        mode = 1'b0;
        tick;
        mode = 1'b1; dwell = 8'd2;
        tick;
        for (int t = 1; t <= 10; t++) tick;
        checks++;
        if (idx !== 3'd3 || ou !== 8'h08) begin failures++; $display("[TB] FAIL freeze_setup: got %h/%0d expected 08/3", ou, idx); end
        en = 1'b0;
        for (int f = 0; f < 5; f++) begin
            tick;
            checks++;
            if (ou !== 8'h08 || idx !== 3'd3 || ouValid !== 1'b1 || wrap !== 1'b0 || inReady !== 1'b0)
                begin failures++; $display("[TB] FAIL freeze_hold[%0d]: got %h/%0d/%b/%b/%b expected 08/3/1/0/0", f, ou, idx, ouValid, wrap, inReady); end
        end
        en = 1'b1;
        tick;
        checks++;
        if (idx !== 3'd3) begin failures++; $display("[TB] FAIL freeze_resume_a: got %0d expected 3", idx); end
        tick;
        checks++;
        if (idx !== 3'd4 || ou !== 8'h10) begin failures++; $display("[TB] FAIL freeze_resume_b: got %h/%0d expected 10/4", ou, idx); end
        mode = 1'b0;
        tick;
        en = 1'b0; inValid = 1'b1; selIn = 3'd1;
        #1;
        checks++;
        if (inReady !== 1'b0) begin failures++; $display("[TB] FAIL freeze_ready: got %b expected 0", inReady); end
        tick;
        checks++;
        if (ou !== 8'h10 || idx !== 3'd4) begin failures++; $display("[TB] FAIL freeze_noaccept: got %h/%0d expected 10/4", ou, idx); end
        en = 1'b1;
        tick;
        checks++;
        if (ou !== 8'h02 || idx !== 3'd1) begin failures++; $display("[TB] FAIL freeze_accept: got %h/%0d expected 02/1", ou, idx); end
        inValid = 1'b0;
    endtask

    task automatic test_mode_switch;
        mode = 1'b1; dwell = 8'd0;
        for (int k = 0; k < 6; k++) tick;
        checks++;
        if (ou !== 8'h20 || idx !== 3'd5) begin failures++; $display("[TB] FAIL mode_setup: got %h/%0d expected 20/5", ou, idx); end
        mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if (ou !== 8'h20 || idx !== 3'd5 || ouValid !== 1'b1)
                begin failures++; $display("[TB] FAIL mode_hold[%0d]: got %h/%0d/%b expected 20/5/1", k, ou, idx, ouValid); end
        end
        inValid = 1'b1; selIn = 3'd2;
        tick;
        inValid = 1'b0;
        checks++;
        if (ou !== 8'h04 || idx !== 3'd2) begin failures++; $display("[TB] FAIL mode_accept: got %h/%0d expected 04/2", ou, idx); end
        mode = 1'b1;
        tick;
        checks++;
        if (ou !== 8'h01 || idx !== 3'd0) begin failures++; $display("[TB] FAIL mode_restart: got %h/%0d expected 01/0", ou, idx); end
    endtask

    task automatic test_reset_mid_scan;
        for (int k = 0; k < 6; k++) tick;
        checks++;
        if (ou !== 8'h40 || idx !== 3'd6) begin failures++; $display("[TB] FAIL rstmid_setup: got %h/%0d expected 40/6", ou, idx); end
        rst = 1'b1;
        tick;
        checks++;
        if (ou !== 8'h00 || ouValid !== 1'b0 || idx !== 3'd0 || wrap !== 1'b0)
            begin failures++; $display("[TB] FAIL rstmid_clear: got %h/%b/%0d/%b expected 00/0/0/0", ou, ouValid, idx, wrap); end
        rst = 1'b0;
        tick;
        checks++;
        if (ou !== 8'h01 || ouValid !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_reenter: got %h/%b expected 01/1", ou, ouValid); end
    endtask

    initial begin
        test_reset;
        test_direct_sweep;
        test_scan_dwell0;
        test_scan_dwell2;
        test_freeze;
        test_mode_switch;
        test_reset_mid_scan;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
